// File: rtl/ppu_vram_ctrl.sv
// PPU VRAM responder: CHR pass-through, nametable CIRAM with mirroring, palette RAM with post-reset clear.
// Optional macro PPU_VRAM_FOUR_SCREEN_EN: 4 KB CIRAM addressed by vram_a[11:0], mirroring input ignored.
module ppu_vram_ctrl #(
  parameter int PAL_W    = 6,
  parameter int CIRAM_AW = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [13:0] vram_a,
  input  logic        vram_r,
  input  logic        vram_w,
  input  logic [7:0]  vram_dout,
  output logic [7:0]  vram_din,
  input  logic [1:0]  mirroring,
  output logic        busy,
  output logic [12:0] chr_a,
  output logic        chr_r,
  output logic        chr_w,
  output logic [7:0]  chr_dout,
  input  logic [7:0]  chr_din
);

`ifdef PPU_VRAM_FOUR_SCREEN_EN
  localparam int NT_AW = 12;
`else
  localparam int NT_AW = CIRAM_AW;
`endif

  typedef enum logic [1:0] {SRC_CHR, SRC_NT, SRC_PAL} src_t;
  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t state_reg;
  logic [4:0] clr_cnt_reg;
  logic busy_reg;

  src_t src_reg;
  logic rd_pend_reg;
  logic [7:0] hold_reg;

  logic [7:0] ciram_mem [0:(1<<NT_AW)-1];
  logic [7:0] ciram_q_reg;
  logic [PAL_W-1:0] pal_mem [0:31];
  logic [PAL_W-1:0] pal_q_reg;

  logic in_chr, in_pal, in_nt;
  logic accept, wr_en, rd_en;
  logic [4:0] pal_idx;
  logic [NT_AW-1:0] nt_addr;
  logic [7:0] pal_rd;
  logic [7:0] fresh_data;

  assign in_chr = ~vram_a[13];
  assign in_pal = (vram_a[13:8] == 6'h3F);
  assign in_nt  = vram_a[13] & ~in_pal;

  assign accept = ce & ~busy_reg & ~reset;
  assign wr_en  = accept & vram_w;
  assign rd_en  = accept & vram_r & ~vram_w;

  // Sprite backdrop entries $10/$14/$18/$1C share storage with $00/$04/$08/$0C.
  always_comb begin
    pal_idx = vram_a[4:0];
    if (vram_a[1:0] == 2'b00) pal_idx[4] = 1'b0;
  end

`ifdef PPU_VRAM_FOUR_SCREEN_EN
  logic unused_mirroring;
  assign unused_mirroring = ^mirroring;
  assign nt_addr = vram_a[11:0];
`else
  logic nt_a10;
  always_comb begin
    nt_a10 = 1'b0;
    case (mirroring)
      2'b00:   nt_a10 = vram_a[11];
      2'b01:   nt_a10 = vram_a[10];
      2'b10:   nt_a10 = 1'b0;
      default: nt_a10 = 1'b1;
    endcase
  end
  assign nt_addr = NT_AW'({nt_a10, vram_a[9:0]});
`endif

  always_ff @(posedge clk) begin
    if (wr_en && in_nt) ciram_mem[nt_addr] <= vram_dout;
    if (rd_en && in_nt) ciram_q_reg <= ciram_mem[nt_addr];
  end

  // Clear writes and PPU writes never overlap: PPU accesses are blocked while busy.
  always_ff @(posedge clk) begin
    if (busy_reg && ce)
      pal_mem[clr_cnt_reg] <= '0;
    else if (wr_en && in_pal)
      pal_mem[pal_idx] <= vram_dout[PAL_W-1:0];
    if (rd_en && in_pal) pal_q_reg <= pal_mem[pal_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_CLEAR;
      clr_cnt_reg <= 5'd0;
      busy_reg    <= 1'b1;
    end else if (ce) begin
      case (state_reg)
        ST_CLEAR: begin
          clr_cnt_reg <= clr_cnt_reg + 5'd1;
          if (clr_cnt_reg == 5'd31) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign pal_rd = 8'(pal_q_reg);

  always_comb begin
    case (src_reg)
      SRC_CHR: fresh_data = chr_din;
      SRC_PAL: fresh_data = pal_rd;
      default: fresh_data = ciram_q_reg;
    endcase
  end

  // Fresh data is shown in the cycle after the request, then frozen in hold_reg.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_reg     <= SRC_NT;
      rd_pend_reg <= 1'b0;
      hold_reg    <= 8'h00;
    end else if (ce) begin
      if (rd_pend_reg) hold_reg <= fresh_data;
      rd_pend_reg <= rd_en;
      if (rd_en) src_reg <= in_chr ? SRC_CHR : (in_pal ? SRC_PAL : SRC_NT);
    end
  end

  assign vram_din = rd_pend_reg ? fresh_data : hold_reg;
  assign busy     = busy_reg;
  assign chr_a    = vram_a[12:0];
  assign chr_dout = vram_dout;
  assign chr_r    = rd_en & in_chr;
  assign chr_w    = wr_en & in_chr;

endmodule

// File: tb/tb_ppu_vram_ctrl.sv
// Randomized bench for ppu_vram_ctrl against an address-map reference model (default build).
module tb_ppu_vram_ctrl;
  logic        clk = 1'b0;
  logic        reset, ce, vram_r, vram_w;
  logic [13:0] vram_a;
  logic [7:0]  vram_dout, vram_din, chr_dout, chr_din;
  logic [1:0]  mirroring;
  logic        busy, chr_r, chr_w;
  logic [12:0] chr_a;

  always #5 clk = ~clk;

  ppu_vram_ctrl dut (
    .clk(clk), .reset(reset), .ce(ce), .vram_a(vram_a), .vram_r(vram_r), .vram_w(vram_w),
    .vram_dout(vram_dout), .vram_din(vram_din), .mirroring(mirroring), .busy(busy),
    .chr_a(chr_a), .chr_r(chr_r), .chr_w(chr_w), .chr_dout(chr_dout), .chr_din(chr_din)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] nt_model [0:2047];
  logic [5:0] pal_model [0:31];
  logic [7:0] exp_din;
  bit prev_read;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Logical nametable 0..3 folded onto two physical 1 KB pages.
  function automatic int nt_phys(input logic [13:0] a, input logic [1:0] m);
    int tbl, off, page;
    tbl = (int'(a) % 4096) / 1024;
    off = int'(a) % 1024;
    case (m)
      2'd0:    page = tbl / 2;
      2'd1:    page = tbl % 2;
      2'd2:    page = 0;
      default: page = 1;
    endcase
    return page * 1024 + off;
  endfunction

  function automatic int pal_slot(input logic [13:0] a);
    int idx;
    idx = int'(a) % 32;
    if (idx >= 16 && idx % 4 == 0) idx -= 16;
    return idx;
  endfunction

  task automatic step(input bit c, input bit r, input bit w, input logic [13:0] a, input logic [7:0] d);
    bit is_chr, is_pal;
    logic [7:0] v;
    ce = c; vram_r = r; vram_w = w; vram_a = a; vram_dout = d;
    is_chr = (a < 14'h2000);
    is_pal = (a >= 14'h3F00);
    @(negedge clk);
    check("vram_din", vram_din, exp_din);
    check("busy", busy, 0);
    check("chr_r", chr_r, c && r && !w && is_chr);
    check("chr_w", chr_w, c && w && is_chr);
    if (is_chr) check("chr_a", chr_a, a[12:0]);
    if (c && w && is_chr) check("chr_dout", chr_dout, d);
    @(posedge clk); #1;
    $display("acc ce=%0d r=%0d w=%0d a=%04h d=%02h mir=%0d", c, r, w, a, d, mirroring);
    prev_read = 0;
    chr_din = 8'($urandom);
    if (c && w) begin
      if (is_pal) pal_model[pal_slot(a)] = d[5:0];
      else if (!is_chr) nt_model[nt_phys(a, mirroring)] = d;
    end else if (c && r) begin
      prev_read = 1;
      if (is_chr) begin
        v = 8'($urandom);
        chr_din = v;
        exp_din = v;
      end else if (is_pal) begin
        exp_din = {2'b00, pal_model[pal_slot(a)]};
      end else begin
        exp_din = nt_model[nt_phys(a, mirroring)];
      end
    end
    vram_r = 0; vram_w = 0;
  endtask

  task automatic do_reset(input int restart_after);
    int n;
    reset = 1; ce = 1; vram_r = 0; vram_w = 0;
    @(posedge clk); #1;
    reset = 0;
    if (restart_after >= 0) begin
      repeat (restart_after) @(posedge clk);
      #1 reset = 1;
      @(posedge clk); #1;
      reset = 0;
    end
    for (int i = 0; i < 32; i++) pal_model[i] = 6'd0;
    exp_din = 8'h00;
    prev_read = 0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      vram_a = (i % 2 == 1) ? 14'h0123 : 14'h0100;
      vram_w = (i % 2 == 0);
      vram_r = (i % 2 == 1);
      vram_dout = 8'h5A;
      @(negedge clk);
      if (!busy) break;
      n++;
      check("busy_din", vram_din, 8'h00);
      check("busy_chr_r", chr_r, 0);
      check("busy_chr_w", chr_w, 0);
      @(posedge clk); #1;
    end
    vram_r = 0; vram_w = 0;
    check("busy_len", n, 32);
    $display("reset restart_after=%0d busy_cycles=%0d", restart_after, n);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(1, 0, 0, 14'h2000, 8'h00);
  endtask

  initial begin
    logic [13:0] a;
    bit c, r, w;
    int sel;
    reset = 1; ce = 1; vram_r = 0; vram_w = 0; vram_a = 0; vram_dout = 0;
    mirroring = 2'd1; chr_din = 0; exp_din = 0;

    do_reset(-1);
    for (int i = 0; i < 32; i++) step(1, 1, 0, 14'h3F00 + 14'(i), 8'h00);
    idle();

    for (int i = 0; i < 16; i++) begin
      step(1, 0, 1, 14'h2000 + 14'(i), 8'h10 + 8'(i));
      step(1, 0, 1, 14'h2400 + 14'(i), 8'h80 + 8'(i));
    end

    mirroring = 2'd1;
    step(1, 0, 1, 14'h2005, 8'hAB);
    step(1, 1, 0, 14'h2805, 8'h00);
    step(1, 1, 0, 14'h2405, 8'h00);
    idle();

    mirroring = 2'd0;
    step(1, 0, 1, 14'h2403, 8'h5C);
    step(1, 1, 0, 14'h2003, 8'h00);
    step(1, 1, 0, 14'h3003, 8'h00);
    idle();

    step(1, 0, 1, 14'h3F10, 8'hFF);
    step(1, 1, 0, 14'h3F00, 8'h00);
    step(1, 1, 0, 14'h3F30, 8'h00);
    step(1, 0, 1, 14'h3F11, 8'h12);
    step(1, 1, 0, 14'h3F01, 8'h00);
    idle();

    step(1, 1, 0, 14'h1234, 8'h00);
    idle();
    idle();

    mirroring = 2'd1;
    step(1, 1, 1, 14'h2000, 8'h99);
    idle();
    step(1, 1, 0, 14'h2000, 8'h00);
    idle();

    for (int k = 0; k < 400; k++) begin
      mirroring = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 2);
      case (sel)
        0:       a = 14'($urandom_range(0, 8191));
        1:       a = 14'h2000 + 14'($urandom_range(0, 3) * 1024) + 14'($urandom_range(0, 15))
                     + (($urandom_range(0, 1) == 1) ? 14'h1000 : 14'h0000);
        default: a = 14'h3F00 + 14'($urandom_range(0, 255));
      endcase
      r = ($urandom_range(0, 1) == 1);
      w = ($urandom_range(0, 2) == 0);
      c = prev_read ? 1'b1 : ($urandom_range(0, 7) != 0);
      step(c, r, w, a, 8'($urandom));
    end
    idle();

    do_reset(10);
    for (int i = 0; i < 32; i++) step(1, 1, 0, 14'h3F00 + 14'(i), 8'h00);
    mirroring = 2'd1;
    for (int i = 0; i < 16; i++) step(1, 1, 0, 14'h2400 + 14'(i), 8'h00);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
